// File: rtl/apb_master_bridge_if.sv
// Command/response stream plus APB4 signal set for apb_master_bridge.
// The master modport is the bridge's view; the slave modport is the environment's.
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;
    logic [2:0]        cmd_prot;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [2:0]        pprot;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB4 master: one valid/ready command becomes one APB transfer with an optional
// wait-state timeout; the response is held until the requester accepts it.
module apb_master_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic              pclk,
    input logic              preset,
    apb_master_bridge_if.master bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic [2:0]        pprot_q, pprot_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= StIdle;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_wdata;
                    pprot_d  = bus.cmd_prot;
                    // APB4 requires pstrb low on reads
                    pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
                    psel_d   = 1'b1;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = StAccess;
            end
            StAccess: begin
                if (bus.pready) begin
                    rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
                    rsp_err_d     = bus.pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = StResp;
                end else begin
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        state_d       = StResp;
                    end
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.cmd_ready   = (state_q == StIdle);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.pprot       = pprot_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: random and directed commands, an APB slave
// model driven by a per-transfer plan, and a response monitor checking a queue.
module tb_apb_master_bridge;
    localparam int TO = 16;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] rdata;
        int          waits;
        logic        slverr;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          rise;
    } exp_t;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   aborted = 1'b0;
    int   force_hold = -1;
    txn_t plan_q[$];
    exp_t exp_q[$];

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    apb_master_bridge_if #(.ADDR_W(12), .DATA_W(16)) bus2 ();

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    apb_master_bridge #(.ADDR_W(12), .DATA_W(16), .TIMEOUT(3)) dut2 (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus2)
    );

    initial forever #5 pclk = ~pclk;
    initial forever begin
        @(posedge pclk);
        cyc++;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int access_cycles(input txn_t t);
        if (TO != 0 && t.waits >= TO) return TO;
        return t.waits + 1;
    endfunction

    // Reference: the response follows from the plan and the timeout rule alone.
    function automatic exp_t model(input txn_t t, input int accept_edge);
        exp_t e;
        e.tmo   = (TO != 0) && (t.waits >= TO);
        e.err   = e.tmo || t.slverr;
        e.rdata = (e.tmo || t.write) ? 32'h0 : t.rdata;
        e.rise  = accept_edge + 1 + access_cycles(t);
        return e;
    endfunction

    function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int wt, input logic [31:0] rd,
                                input logic se);
        txn_t t;
        t.write = w; t.addr = a; t.wdata = d; t.strb = s; t.prot = 3'($urandom);
        t.rdata = rd; t.waits = wt; t.slverr = se;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        int r;
        r = $urandom_range(0, 9);
        return mk(1'($urandom), $urandom, $urandom, 4'($urandom),
                  (r < 7) ? r % 4 : 13 + $urandom_range(0, 6), $urandom,
                  $urandom_range(0, 3) == 0);
    endfunction

    task automatic issue(input txn_t t);
        int n;
        n = 0;
        @(negedge pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = t.write;
        bus.cmd_addr  = t.addr;
        bus.cmd_wdata = t.wdata;
        bus.cmd_strb  = t.strb;
        bus.cmd_prot  = t.prot;
        while (!bus.cmd_ready && n < 400) begin
            @(negedge pclk);
            n++;
        end
        if (!bus.cmd_ready) begin
            chk("cmd_accept_ready", bus.cmd_ready, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        plan_q.push_back(t);
        exp_q.push_back(model(t, cyc + 1));
        @(posedge pclk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_strb  = 4'($urandom);
        bus.cmd_write = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 400) begin
            @(negedge pclk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // APB slave model: follows the plan popped at each SETUP phase.
    initial begin
        txn_t cur;
        bit   active;
        int   k;
        active = 1'b0;
        k = 0;
        bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
        forever begin
            @(negedge pclk);
            if (bus.psel && !bus.penable) begin
                chk("setup_single_cycle", active, 0);
                if (plan_q.size() == 0) begin
                    chk("setup_has_plan", plan_q.size(), 1);
                end else begin
                    cur = plan_q.pop_front();
                    active = 1'b1;
                    k = 0;
                    chk("setup_fields", {bus.paddr, bus.pwdata, bus.pstrb, bus.pwrite, bus.pprot},
                        {cur.addr, cur.wdata, cur.write ? cur.strb : 4'h0, cur.write, cur.prot});
                end
                bus.pready = 1'b0;
            end else if (bus.psel && bus.penable && active) begin
                chk("access_stable", {bus.paddr, bus.pwdata, bus.pstrb, bus.pwrite, bus.pprot},
                    {cur.addr, cur.wdata, cur.write ? cur.strb : 4'h0, cur.write, cur.prot});
                bus.pready  = (k == cur.waits);
                bus.prdata  = bus.pready ? cur.rdata : $urandom;
                bus.pslverr = bus.pready ? cur.slverr : 1'($urandom);
                k++;
            end else if (!bus.psel) begin
                if (active && !aborted) chk("access_cycles", k, access_cycles(cur));
                active = 1'b0;
                bus.pready = 1'b0;
            end
        end
    end

    // Response monitor: pops the expectation when rsp_valid first appears.
    initial begin
        exp_t e;
        bit   seen;
        int   hold;
        int   held;
        seen = 1'b0; hold = 0; held = 0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge pclk);
            if (preset) begin
                seen = 1'b0;
                bus.rsp_ready = 1'b0;
            end else if (bus.rsp_valid) begin
                chk("cmd_ready_low_in_resp", bus.cmd_ready, 0);
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_expected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_latency", cyc, e.rise);
                        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                        chk("rsp_err_tmo", {bus.rsp_err, bus.rsp_timeout}, {e.err, e.tmo});
                        chk("psel_low_in_resp", {bus.psel, bus.penable}, 2'b00);
                    end
                    seen = 1'b1;
                    held = 0;
                    hold = (force_hold >= 0) ? force_hold : $urandom_range(0, 3);
                end else begin
                    chk("rsp_stable", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout},
                        {e.rdata, e.err, e.tmo});
                end
                bus.rsp_ready = (held >= hold);
                held++;
            end else begin
                if (seen) chk("cmd_ready_after_rsp", bus.cmd_ready, 1);
                seen = 1'b0;
                bus.rsp_ready = 1'($urandom);
            end
        end
    end

    initial begin
        int n;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_strb = '0; bus.cmd_prot = '0;
        bus2.cmd_valid = 1'b0; bus2.cmd_write = 1'b0; bus2.cmd_addr = '0;
        bus2.cmd_wdata = '0; bus2.cmd_strb = '0; bus2.cmd_prot = '0;
        bus2.rsp_ready = 1'b0; bus2.pready = 1'b0; bus2.prdata = '0; bus2.pslverr = 1'b0;

        repeat (3) @(negedge pclk);
        chk("reset_ctrl", {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err,
                           bus.rsp_timeout, bus.cmd_ready}, 7'b0000001);
        chk("reset_data", {bus.paddr, bus.pwdata, bus.pstrb, bus.pprot, bus.rsp_rdata}, '0);
        preset = 1'b0;

        // Directed: zero-wait write, waited read, timeout boundary, slave error held.
        force_hold = 0;
        issue(mk(1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 0, 32'h1111_2222, 1'b0));
        issue(mk(1'b0, 32'h0000_0004, 32'h0BAD_F00D, 4'hF, 3, 32'hDEAD_BEEF, 1'b0));
        issue(mk(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1000, 32'h1234_5678, 1'b0));
        issue(mk(1'b0, 32'h0000_0024, 32'h0, 4'h0, 15, 32'hCAFE_F00D, 1'b0));
        issue(mk(1'b0, 32'h0000_0028, 32'h0, 4'h0, 16, 32'hCAFE_F00D, 1'b0));
        drain();
        force_hold = 5;
        issue(mk(1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'h3, 1, 32'h0, 1'b1));
        drain();

        force_hold = -1;
        for (int i = 0; i < 60; i++) issue(rand_txn());
        drain();

        // Reset during ACCESS: transfer vanishes, next command completes normally.
        issue(mk(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1000, 32'h0, 1'b0));
        n = 0;
        while (!(bus.psel && bus.penable) && n < 20) begin
            @(negedge pclk);
            n++;
        end
        chk("reached_access", {bus.psel, bus.penable}, 2'b11);
        aborted = 1'b1;
        preset = 1'b1;
        @(posedge pclk);
        #1;
        chk("midreset_outputs", {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}, 4'b0001);
        @(negedge pclk);
        preset = 1'b0;
        exp_q.delete();
        plan_q.delete();
        repeat (2) @(negedge pclk);
        aborted = 1'b0;
        issue(mk(1'b0, 32'h0000_0044, 32'h0, 4'h0, 2, 32'h0F0F_A5A5, 1'b0));
        drain();

        // Narrow build: 12-bit address, 16-bit data, TIMEOUT=3.
        @(negedge pclk);
        chk("n_cmd_ready", bus2.cmd_ready, 1);
        bus2.cmd_valid = 1'b1; bus2.cmd_write = 1'b0; bus2.cmd_addr = 12'h0FE;
        bus2.cmd_wdata = 16'h1234; bus2.cmd_strb = 2'b11; bus2.cmd_prot = 3'b010;
        @(posedge pclk);
        #1;
        bus2.cmd_valid = 1'b0;
        chk("n_setup", {bus2.psel, bus2.penable, bus2.pwrite, bus2.paddr, bus2.pstrb, bus2.pprot},
            {3'b100, 12'h0FE, 2'b00, 3'b010});
        bus2.pready = 1'b1; bus2.prdata = 16'hBEEF;
        @(posedge pclk);
        #1;
        chk("n_access", {bus2.psel, bus2.penable}, 2'b11);
        @(posedge pclk);
        #1;
        chk("n_rsp", {bus2.rsp_valid, bus2.rsp_rdata, bus2.rsp_err, bus2.rsp_timeout, bus2.psel},
            {1'b1, 16'hBEEF, 3'b000});
        bus2.pready = 1'b0; bus2.prdata = 16'h7777; bus2.rsp_ready = 1'b1;
        @(posedge pclk);
        #1;
        chk("n_rsp_done", {bus2.rsp_valid, bus2.cmd_ready}, 2'b01);
        bus2.cmd_valid = 1'b1; bus2.cmd_write = 1'b1; bus2.cmd_addr = 12'h3A2;
        @(posedge pclk);
        #1;
        bus2.cmd_valid = 1'b0;
        n = 0;
        while (!bus2.rsp_valid && n < 20) begin
            @(posedge pclk);
            #1;
            if (bus2.penable) n++;
            else if (!bus2.rsp_valid && !bus2.psel) n = 100;
        end
        chk("n_timeout_cycles", n, 3);
        chk("n_timeout_rsp", {bus2.rsp_valid, bus2.rsp_rdata, bus2.rsp_err, bus2.rsp_timeout},
            {1'b1, 16'h0, 2'b11});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
